wd_service_gen: RTL and testbench
=================================

Name: wd_service_gen

Overview:
Watchdog service generator. It is the producing side of the watchdog link: it drives WDSRVC, SWSTAT and FWOVR into wd_fail_detector and consumes WDFAIL back.
- Converts software heartbeats into correctly windowed, fixed-width service pulses.
- Suppresses early heartbeats.
- Raises FWOVR on a missed service window.
- Freezes once the detector reports failure.

Parameters:
CLOSED_CYC, 16, cycles after each service during which service is forbidden (closed window)
OPEN_CYC, 32, cycles of open window in which a heartbeat is accepted
PULSE_CYC, 2, WDSRVC high width in cycles (>=1)
CNT_W, 8, window counter width; must hold max(CLOSED_CYC, OPEN_CYC, PULSE_CYC)
ERR_W, 4, width of saturating early-heartbeat counter

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  reset, synchronous, active-low
HBEAT  input  1  software heartbeat, single-cycle request, synchronous to CLK
SWOK  input  1  software health level, asynchronous source
WDFAIL  input  1  failure flag returned by wd_fail_detector
WDSRVC  output  1  watchdog service pulse, registered
SWSTAT  output  1  synchronised software status, registered
FWOVR  output  1  firmware override / window-timeout flag, sticky, registered
GSTAT  output  3  current FSM state encoding
EARLY_CNT  output  ERR_W  saturating count of heartbeats rejected in the closed window

Behaviour:
- Reset: RST_N low at a rising CLK edge gives the following values on the next cycle. Reset overrides all other events, including a pulse in progress (WDSRVC drops on the cycle after the reset edge).
  - WDSRVC=0, SWSTAT=0, FWOVR=0, EARLY_CNT=0.
  - Counter=0, state=CLOSED, GSTAT=3'b001.
- SWSTAT: SWOK passes through a 2-flop synchroniser. SWSTAT equals the second flop, so latency is 2 cycles. SWSTAT keeps tracking in every state except FAILED.
- States (GSTAT encoding):
  - CLOSED=001, OPEN=010, SERVICE=011, TIMEOUT=100, FAILED=111.
  - 000 is unused. If the state register ever holds an illegal value, the next state is FAILED.
- CLOSED:
  - Counter increments each cycle. On counter==CLOSED_CYC-1: counter clears, go to OPEN.
  - HBEAT here is rejected: no pulse; EARLY_CNT increments, saturating at all-ones; state and counter are unaffected.
- OPEN:
  - Counter increments each cycle.
  - HBEAT: counter clears, go to SERVICE. WDSRVC goes high on the next cycle.
  - Counter==OPEN_CYC-1 without HBEAT: go to TIMEOUT.
  - HBEAT on that same last cycle is in-window: SERVICE wins and no timeout occurs.
- SERVICE:
  - WDSRVC=1 for exactly PULSE_CYC cycles.
  - Then WDSRVC=0, counter clears, go to CLOSED. A new window starts from the pulse end.
  - HBEAT during SERVICE is ignored and not counted.
- TIMEOUT:
  - One cycle. FWOVR set to 1 (sticky until reset), WDSRVC=0.
  - Next state FAILED.
- FAILED:
  - Terminal until reset.
  - WDSRVC=0, FWOVR holds its value, SWSTAT frozen at its last value, counter frozen, HBEAT ignored.
- WDFAIL:
  - WDFAIL=1 in any non-reset state forces FAILED on the next cycle. This has priority over HBEAT, window expiry and an in-progress pulse; a pulse is truncated with WDSRVC=0 next cycle.
  - WDFAIL does not set FWOVR.
- Simultaneous events, priority highest first:
  1. reset
  2. illegal state
  3. WDFAIL
  4. in-window HBEAT
  5. window expiry
- Arithmetic: counter compares are on CNT_W-bit unsigned values. The counter never wraps; it is always cleared by a transition before overflow. Parameter legality (CLOSED_CYC>=1, OPEN_CYC>=1, PULSE_CYC>=1, all < 2**CNT_W) is checked at elaboration.

Decomposition:
- Shared package wd_pkg:
  - State encoding constants CLOSED/OPEN/SERVICE/TIMEOUT/FAILED and the 3-bit state type.
  - FLSTAT code constants (000 override, 001 sw-down service, 010 early service, 011 missed service, 100 idle), so detector, generator and benches agree.
- One natural sub-module: wd_sync2, the 2-flop synchroniser for SWOK, with reset value 0.
- FSM, counter and EARLY_CNT stay in wd_service_gen.

Test Plan:
1. Reset release with HBEAT at cycle 20 (inside OPEN, since the window opens at cycle 16) -> WDSRVC high cycles 21-22; GSTAT sequence 001, 010, 011, 001; FWOVR=0.
2. HBEAT at cycles 3 and 7 (CLOSED) -> no WDSRVC; EARLY_CNT=2. Then 20 HBEATs in CLOSED -> EARLY_CNT saturates at 15.
3. No HBEAT after reset -> TIMEOUT (GSTAT=100) at cycle 48, FWOVR=1 from cycle 49, GSTAT=111 thereafter. A later HBEAT gives no pulse.
4. HBEAT exactly on the last OPEN cycle (counter==31) -> SERVICE entered, pulse issued, FWOVR stays 0.
5. WDFAIL=1 on the first cycle of a pulse -> WDSRVC low the next cycle, GSTAT=111, FWOVR=0. SWSTAT stays frozen even when SWOK toggles.
6. SWOK 0->1 -> SWSTAT rises 2 cycles later. RST_N low mid-pulse -> WDSRVC=0 and all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/wd_pkg.sv
// wd_pkg
// Shared definitions for the watchdog link, used by wd_service_gen,
// wd_fail_detector and their benches so all sides agree on encodings.
//   wd_state_t  : 3-bit FSM state type, also driven out on GSTAT
//   FLSTAT_*    : failure-status codes reported by the detector
package wd_pkg;

  // 3'b000 is deliberately unused so a cleared register is caught as illegal.
  typedef enum logic [2:0] {
    ST_CLOSED  = 3'b001,
    ST_OPEN    = 3'b010,
    ST_SERVICE = 3'b011,
    ST_TIMEOUT = 3'b100,
    ST_FAILED  = 3'b111
  } wd_state_t;

  localparam logic [2:0] FLSTAT_OVERRIDE = 3'b000;
  localparam logic [2:0] FLSTAT_SW_DOWN  = 3'b001;
  localparam logic [2:0] FLSTAT_EARLY    = 3'b010;
  localparam logic [2:0] FLSTAT_MISSED   = 3'b011;
  localparam logic [2:0] FLSTAT_IDLE     = 3'b100;

endpackage

// File: rtl/wd_sync2.sv
// wd_sync2
// Two-flop synchroniser for a single asynchronous level, with a hold enable
// so the synchronised value can be frozen.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both flops to 0
//   en    : 1 = track d, 0 = hold both flops
//   d     : asynchronous input level
//   q     : synchronised level, 2 cycles latency
module wd_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else if (en) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wd_service_gen.sv
// wd_service_gen
// Watchdog service generator: turns software heartbeats into windowed,
// fixed-width service pulses for wd_fail_detector, rejects early heartbeats,
// flags a missed window with FWOVR and freezes once WDFAIL is reported.
//   CLK       : system clock
//   RST_N     : synchronous active-low reset
//   HBEAT     : single-cycle software heartbeat request
//   SWOK      : asynchronous software health level
//   WDFAIL    : failure flag from wd_fail_detector
//   WDSRVC    : service pulse, PULSE_CYC cycles wide
//   SWSTAT    : synchronised SWOK, frozen in FAILED
//   FWOVR     : sticky window-timeout flag
//   GSTAT     : current FSM state encoding
//   EARLY_CNT : saturating count of heartbeats rejected in the closed window
module wd_service_gen
  import wd_pkg::*;
#(
  parameter int CLOSED_CYC = 16,
  parameter int OPEN_CYC   = 32,
  parameter int PULSE_CYC  = 2,
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HBEAT,
  input  logic             SWOK,
  input  logic             WDFAIL,
  output logic             WDSRVC,
  output logic             SWSTAT,
  output logic             FWOVR,
  output logic [2:0]       GSTAT,
  output logic [ERR_W-1:0] EARLY_CNT
);

  if (CLOSED_CYC < 1 || OPEN_CYC < 1 || PULSE_CYC < 1 ||
      CLOSED_CYC >= (1 << CNT_W) || OPEN_CYC >= (1 << CNT_W) ||
      PULSE_CYC >= (1 << CNT_W)) begin : g_bad_param
    $error("wd_service_gen: window parameters out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CLOSED_LAST = CNT_W'(CLOSED_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST   = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);

  wd_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             sync_en;

  // SWSTAT keeps tracking everywhere except FAILED, where it is frozen.
  assign sync_en = (state != ST_FAILED);

  wd_sync2 u_swok_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (sync_en),
    .d     (SWOK),
    .q     (SWSTAT)
  );

  assign GSTAT = state;

  // Each legal state checks WDFAIL first so it beats heartbeats, window
  // expiry and a pulse in progress; illegal encodings fall into default.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_CLOSED;
      cnt       <= '0;
      WDSRVC    <= 1'b0;
      FWOVR     <= 1'b0;
      EARLY_CNT <= '0;
    end else begin
      case (state)
        ST_CLOSED: begin
          if (WDFAIL) begin
            state  <= ST_FAILED;
            WDSRVC <= 1'b0;
          end else begin
            if (HBEAT && (EARLY_CNT != '1))
              EARLY_CNT <= EARLY_CNT + ERR_W'(1);
            if (cnt == CLOSED_LAST) begin
              cnt   <= '0;
              state <= ST_OPEN;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_OPEN: begin
          if (WDFAIL) begin
            state  <= ST_FAILED;
            WDSRVC <= 1'b0;
          end else if (HBEAT) begin
            cnt    <= '0;
            state  <= ST_SERVICE;
            WDSRVC <= 1'b1;
          end else if (cnt == OPEN_LAST) begin
            state <= ST_TIMEOUT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SERVICE: begin
          // The next closed window is timed from the end of the pulse.
          if (WDFAIL) begin
            state  <= ST_FAILED;
            WDSRVC <= 1'b0;
          end else if (cnt == PULSE_LAST) begin
            cnt    <= '0;
            state  <= ST_CLOSED;
            WDSRVC <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          if (WDFAIL) begin
            state  <= ST_FAILED;
            WDSRVC <= 1'b0;
          end else begin
            FWOVR  <= 1'b1;
            WDSRVC <= 1'b0;
            state  <= ST_FAILED;
          end
        end
        ST_FAILED: begin
          WDSRVC <= 1'b0;
        end
        default: begin
          state  <= ST_FAILED;
          WDSRVC <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wd_service_gen.sv
// tb_wd_service_gen
// Directed bench for wd_service_gen. Cycle 0 is the first cycle after the
// last reset edge; inputs set at the negedge of cycle k are sampled at the
// edge ending cycle k. Expected values are queued with the cycle at which
// they must appear and compared at the negedge of that cycle.
module tb_wd_service_gen;
  import wd_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic       HBEAT;
  logic       SWOK;
  logic       WDFAIL;
  logic       WDSRVC;
  logic       SWSTAT;
  logic       FWOVR;
  logic [2:0] GSTAT;
  logic [3:0] EARLY_CNT;

  wd_service_gen #(
    .CLOSED_CYC (16),
    .OPEN_CYC   (32),
    .PULSE_CYC  (2),
    .CNT_W      (8),
    .ERR_W      (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .HBEAT     (HBEAT),
    .SWOK      (SWOK),
    .WDFAIL    (WDFAIL),
    .WDSRVC    (WDSRVC),
    .SWSTAT    (SWSTAT),
    .FWOVR     (FWOVR),
    .GSTAT     (GSTAT),
    .EARLY_CNT (EARLY_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog_timer: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  typedef enum int {F_SRVC, F_SWSTAT, F_FWOVR, F_GSTAT, F_EARLY} field_t;

  typedef struct {
    int         at;
    field_t     fld;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  task automatic push_exp(input int at, input field_t fld, input logic [3:0] val, input string tag);
    exp_t e;
    e.at  = at;
    e.fld = fld;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic hb, input logic wdf, input logic swok);
    RST_N  = rst_n;
    HBEAT  = hb;
    WDFAIL = wdf;
    SWOK   = swok;
  endtask

  task automatic checkOutput();
    int i;
    logic [3:0] obs;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at <= cyc) begin
        case (sb[i].fld)
          F_SRVC:   obs = {3'b000, WDSRVC};
          F_SWSTAT: obs = {3'b000, SWSTAT};
          F_FWOVR:  obs = {3'b000, FWOVR};
          F_GSTAT:  obs = {1'b0, GSTAT};
          default:  obs = EARLY_CNT;
        endcase
        checks++;
        if (sb[i].at < cyc) begin
          errors++;
          $error("[TB] FAIL %s: stale entry for cycle %0d at cycle %0d observed=%0h expected=%0h",
                 sb[i].tag, sb[i].at, cyc, obs, sb[i].val);
        end else begin
          assert (obs === sb[i].val) else begin
            errors++;
            $error("[TB] FAIL %s @cyc %0d: observed=%0h expected=%0h", sb[i].tag, cyc, obs, sb[i].val);
          end
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Anything still queued was never reached and counts against the run.
  task automatic flush_sb();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: never reached, observed=none expected=%0h at cycle %0d",
             sb[0].tag, sb[0].val, sb[0].at);
      void'(sb.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    checkOutput();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic hbeat_at(input int c);
    run_to(c);
    HBEAT = 1'b1;
    tick();
    HBEAT = 1'b0;
  endtask

  task automatic do_reset(input logic swok);
    flush_sb();
    applyStimulus(1'b0, 1'b0, 1'b0, swok);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    cyc = 0;
    push_exp(0, F_GSTAT,  4'h1, "rst_gstat");
    push_exp(0, F_SRVC,   4'h0, "rst_wdsrvc");
    push_exp(0, F_FWOVR,  4'h0, "rst_fwovr");
    push_exp(0, F_EARLY,  4'h0, "rst_early");
    push_exp(0, F_SWSTAT, 4'h0, "rst_swstat");
    checkOutput();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // 1: heartbeat inside the open window
    do_reset(1'b0);
    push_exp(15, F_GSTAT, 4'h1, "t1_closed_last");
    push_exp(16, F_GSTAT, 4'h2, "t1_open");
    push_exp(20, F_SRVC,  4'h0, "t1_no_pulse_yet");
    push_exp(21, F_GSTAT, 4'h3, "t1_service");
    push_exp(21, F_SRVC,  4'h1, "t1_pulse_c21");
    push_exp(22, F_SRVC,  4'h1, "t1_pulse_c22");
    push_exp(23, F_SRVC,  4'h0, "t1_pulse_end");
    push_exp(23, F_GSTAT, 4'h1, "t1_back_closed");
    push_exp(23, F_FWOVR, 4'h0, "t1_fwovr");
    hbeat_at(20);
    run_to(25);

    // 2: early heartbeats and saturation
    do_reset(1'b0);
    push_exp(4,  F_EARLY, 4'h1, "t2_early1");
    push_exp(4,  F_SRVC,  4'h0, "t2_no_pulse4");
    push_exp(8,  F_EARLY, 4'h2, "t2_early2");
    push_exp(8,  F_GSTAT, 4'h1, "t2_still_closed");
    push_exp(16, F_EARLY, 4'hA, "t2_early10");
    push_exp(17, F_EARLY, 4'hA, "t2_open_hb_not_counted");
    push_exp(17, F_SRVC,  4'h1, "t2_pulse17");
    push_exp(18, F_SRVC,  4'h1, "t2_pulse18");
    push_exp(19, F_SRVC,  4'h0, "t2_pulse_end");
    push_exp(19, F_EARLY, 4'hA, "t2_service_hb_ignored");
    push_exp(19, F_GSTAT, 4'h1, "t2_closed_again");
    push_exp(20, F_EARLY, 4'hB, "t2_early11");
    push_exp(24, F_EARLY, 4'hF, "t2_early15");
    push_exp(25, F_SRVC,  4'h0, "t2_no_pulse25");
    push_exp(31, F_EARLY, 4'hF, "t2_saturated");
    push_exp(31, F_GSTAT, 4'h1, "t2_closed31");
    hbeat_at(3);
    hbeat_at(7);
    run_to(8);
    HBEAT = 1'b1;
    run_to(31);
    HBEAT = 1'b0;
    run_to(32);

    // 3: missed window
    do_reset(1'b0);
    push_exp(47, F_GSTAT, 4'h2, "t3_open_last");
    push_exp(48, F_GSTAT, 4'h4, "t3_timeout");
    push_exp(48, F_FWOVR, 4'h0, "t3_fwovr_not_yet");
    push_exp(49, F_FWOVR, 4'h1, "t3_fwovr_set");
    push_exp(49, F_GSTAT, 4'h7, "t3_failed");
    push_exp(56, F_SRVC,  4'h0, "t3_no_pulse56");
    push_exp(57, F_SRVC,  4'h0, "t3_no_pulse57");
    push_exp(57, F_GSTAT, 4'h7, "t3_failed57");
    push_exp(60, F_FWOVR, 4'h1, "t3_fwovr_sticky");
    hbeat_at(55);
    run_to(61);

    // 4: heartbeat on the last open cycle
    do_reset(1'b0);
    push_exp(47, F_GSTAT, 4'h2, "t4_open_last");
    push_exp(48, F_GSTAT, 4'h3, "t4_service");
    push_exp(48, F_SRVC,  4'h1, "t4_pulse48");
    push_exp(49, F_SRVC,  4'h1, "t4_pulse49");
    push_exp(50, F_SRVC,  4'h0, "t4_pulse_end");
    push_exp(50, F_GSTAT, 4'h1, "t4_closed");
    push_exp(51, F_FWOVR, 4'h0, "t4_no_fwovr");
    hbeat_at(47);
    run_to(52);

    // 5: WDFAIL truncates a pulse and freezes SWSTAT
    do_reset(1'b1);
    push_exp(2,  F_SWSTAT, 4'h1, "t5_swstat_up");
    push_exp(21, F_SRVC,   4'h1, "t5_pulse_start");
    push_exp(22, F_SRVC,   4'h0, "t5_pulse_cut");
    push_exp(22, F_GSTAT,  4'h7, "t5_failed");
    push_exp(22, F_FWOVR,  4'h0, "t5_no_fwovr");
    push_exp(30, F_SWSTAT, 4'h1, "t5_swstat_frozen");
    push_exp(30, F_GSTAT,  4'h7, "t5_failed30");
    hbeat_at(20);
    WDFAIL = 1'b1;
    tick();
    WDFAIL = 1'b0;
    run_to(23);
    SWOK = 1'b0;
    run_to(31);

    // 6: synchroniser latency, then reset in the middle of a pulse
    do_reset(1'b0);
    push_exp(6,  F_SWSTAT, 4'h0, "t6_swstat_lat1");
    push_exp(7,  F_SWSTAT, 4'h1, "t6_swstat_lat2");
    push_exp(11, F_EARLY,  4'h1, "t6_early1");
    push_exp(21, F_SRVC,   4'h1, "t6_pulse");
    push_exp(22, F_SRVC,   4'h0, "t6_rst_wdsrvc");
    push_exp(22, F_GSTAT,  4'h1, "t6_rst_gstat");
    push_exp(22, F_FWOVR,  4'h0, "t6_rst_fwovr");
    push_exp(22, F_EARLY,  4'h0, "t6_rst_early");
    push_exp(22, F_SWSTAT, 4'h0, "t6_rst_swstat");
    run_to(5);
    SWOK = 1'b1;
    hbeat_at(10);
    hbeat_at(20);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    run_to(24);

    flush_sb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
